mul_seq_ctrl: RTL and testbench

Multi-cycle sequencer for the integer MUL operation (ALUControl 3'b011) in the mini-MIPS execute stage. It accepts a MUL issued by the decode/ALU-control path and runs a radix-2 shift-add multiply over WIDTH cycles. While the multiply runs it holds the pipeline with a stall signal, then returns the low WIDTH bits of the product with a one-cycle done pulse. Non-MUL operations pass through without it; flush and reset abort an in-flight multiply.

---
 rtl/mul_seq_ctrl.sv | 116 +++++++++++
 tb/tb_mul_seq_ctrl.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/mul_seq_ctrl.sv
// rtl/mul_seq_ctrl.sv - multi-cycle shift-add MUL sequencer for the execute stage
//
// Purpose: accepts a MUL (alu_control 3'b011) from the execute stage and runs a
// radix-2 shift-add multiply over WIDTH cycles. The pipeline is held with stall
// while the multiply runs. The low WIDTH bits of the product are returned
// together with a one-cycle done pulse. WIDTH must be at least 2.
//
// Ports:
//   clk          rising-edge clock
//   rst          asynchronous active-high reset
//   start        execute stage holds a valid instruction
//   alu_control  ALU control code; only 3'b011 (MUL) starts a multiply
//   op_a         multiplicand, sampled only at accept
//   op_b         multiplier, sampled only at accept
//   flush        synchronous abort of any in-flight multiply
//   stall        combinational pipeline hold (accept cycle plus all RUN cycles)
//   busy         registered, high in RUN and DONE
//   done         registered single-cycle pulse, result valid
//   result       registered low WIDTH bits of op_a*op_b, held until next completion

module mul_seq_ctrl #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [2:0]       alu_control,
   input  logic [WIDTH-1:0] op_a,
   input  logic [WIDTH-1:0] op_b,
   input  logic             flush,
   output logic             stall,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] result
);

   localparam logic [2:0]    ALU_MUL = 3'b011;
   localparam int            CW      = $clog2(WIDTH) + 1;
   localparam logic [CW-1:0] LAST    = CW'(WIDTH - 1);

   typedef enum logic [1:0] {
      S_IDLE,
      S_RUN,
      S_DONE
   } state_t;

   state_t           state;
   logic [WIDTH-1:0] mcand;
   logic [WIDTH-1:0] mplier;
   logic [WIDTH-1:0] acc;
   logic [CW-1:0]    count;
   logic             accept;
   logic [WIDTH-1:0] acc_next;

   assign accept   = (state == S_IDLE) && start && (alu_control == ALU_MUL) && !flush;
   assign stall    = accept || (state == S_RUN);
   // Partial-product add for the current multiplier bit; wraps modulo 2^WIDTH.
   assign acc_next = mplier[0] ? (acc + mcand) : acc;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state  <= S_IDLE;
         mcand  <= '0;
         mplier <= '0;
         acc    <= '0;
         count  <= '0;
         busy   <= 1'b0;
         done   <= 1'b0;
         result <= '0;
      end else begin
         case (state)
            S_IDLE: begin
               done <= 1'b0;
               if (accept) begin
                  mcand  <= op_a;
                  mplier <= op_b;
                  acc    <= '0;
                  count  <= '0;
                  busy   <= 1'b1;
                  state  <= S_RUN;
               end
            end
            S_RUN: begin
               if (flush) begin
                  // Abort: result keeps the previous completed product.
                  busy  <= 1'b0;
                  state <= S_IDLE;
               end else begin
                  acc    <= acc_next;
                  mcand  <= mcand << 1;
                  mplier <= mplier >> 1;
                  count  <= count + 1'b1;
                  // Fixed WIDTH iterations; no early exit on a zero multiplier.
                  if (count == LAST) begin
                     result <= acc_next;
                     done   <= 1'b1;
                     state  <= S_DONE;
                  end
               end
            end
            S_DONE: begin
               // start is not re-sampled here so a held instruction is not re-accepted.
               done  <= 1'b0;
               busy  <= 1'b0;
               state <= S_IDLE;
            end
            default: begin
               done  <= 1'b0;
               busy  <= 1'b0;
               state <= S_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_mul_seq_ctrl.sv
// tb/tb_mul_seq_ctrl.sv - scoreboard testbench for mul_seq_ctrl

module tb_mul_seq_ctrl;

   logic        clk;
   logic        rst;
   logic        start;
   logic [2:0]  alu_control;
   logic [31:0] op_a;
   logic [31:0] op_b;
   logic        flush;
   logic        stall;
   logic        busy;
   logic        done;
   logic [31:0] result;

   typedef struct {
      logic [31:0] res;
      int          cyc;
   } exp_t;

   exp_t sb[$];
   int   cyc;
   int   n_checks;
   int   n_fail;

   mul_seq_ctrl #(.WIDTH(32)) dut (
      .clk         (clk),
      .rst         (rst),
      .start       (start),
      .alu_control (alu_control),
      .op_a        (op_a),
      .op_b        (op_b),
      .flush       (flush),
      .stall       (stall),
      .busy        (busy),
      .done        (done),
      .result      (result)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      n_checks++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, req, cyc);
      end
   endtask

   // Monitor: pops an expectation whenever the DUT signals done.
   always @(negedge clk) begin
      if (!rst && done) begin
         if (sb.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected_done: got done=1 expected none (cycle %0d)", cyc);
         end else begin
            exp_t e;
            e = sb.pop_front();
            check("result", result, e.res);
            check("done_cycle", cyc, e.cyc);
            check("busy_at_done", busy, 1'b1);
         end
      end
   end

   // Issue a MUL at the current cycle (called just after a rising edge) and
   // measure the stall length. Returns just after the edge into cycle A+34.
   task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic [31:0] expv);
      int n;
      exp_t e;
      start       = 1'b1;
      alu_control = 3'b011;
      op_a        = a;
      op_b        = b;
      e.res = expv;
      e.cyc = cyc + 33;
      sb.push_back(e);
      n = 0;
      @(negedge clk);
      while (stall && n < 100) begin
         n++;
         @(negedge clk);
      end
      check("stall_len", n, 33);
      @(posedge clk);
      #1;
   endtask

   initial begin
      int a0;
      int n;
      n_checks    = 0;
      n_fail      = 0;
      rst         = 1'b1;
      start       = 1'b0;
      alu_control = 3'b000;
      op_a        = '0;
      op_b        = '0;
      flush       = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check("rst_stall", stall, 1'b0);
      check("rst_busy", busy, 1'b0);
      check("rst_done", done, 1'b0);
      check("rst_result", result, 32'h0);
      rst = 1'b0;
      @(posedge clk);
      #1;

      issue(32'd3, 32'd5, 32'd15);
      start = 1'b0;
      issue(32'h0001_0000, 32'h0001_0000, 32'h0);
      start = 1'b0;
      issue(32'h1234_5678, 32'h0, 32'h0);
      start = 1'b0;
      issue(32'hFFFF_FFFF, 32'd7, 32'hFFFF_FFF9);
      start = 1'b0;

      // Non-MUL instruction is ignored
      start       = 1'b1;
      alu_control = 3'b010;
      op_a        = 32'd11;
      op_b        = 32'd13;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         check("nonmul_stall", stall, 1'b0);
         check("nonmul_busy", busy, 1'b0);
         check("nonmul_done", done, 1'b0);
      end
      check("nonmul_result", result, 32'hFFFF_FFF9);
      @(posedge clk);
      #1;
      start = 1'b0;

      // Flush mid-run
      start       = 1'b1;
      alu_control = 3'b011;
      op_a        = 32'd6;
      op_b        = 32'd7;
      a0          = cyc;
      repeat (10) @(posedge clk);
      #1;
      check("flush_at_cycle", cyc, a0 + 10);
      flush = 1'b1;
      @(posedge clk);
      #1;
      flush = 1'b0;
      check("flush_busy", busy, 1'b0);
      check("flush_done", done, 1'b0);
      check("flush_result", result, 32'hFFFF_FFF9);
      issue(32'd2, 32'd9, 32'd18);
      start = 1'b0;

      // Reset mid-run
      start       = 1'b1;
      alu_control = 3'b011;
      op_a        = 32'd7;
      op_b        = 32'd7;
      repeat (5) @(posedge clk);
      #2;
      start = 1'b0;
      rst   = 1'b1;
      #1;
      check("mrst_stall", stall, 1'b0);
      check("mrst_busy", busy, 1'b0);
      check("mrst_done", done, 1'b0);
      check("mrst_result", result, 32'h0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      @(posedge clk);
      #1;
      issue(32'd4, 32'd4, 32'd16);
      start = 1'b0;

      // Back-to-back with start held high
      issue(32'd10, 32'd10, 32'd100);
      issue(32'h1234_5678, 32'd2, 32'h2468_ACF0);
      start = 1'b0;
      n = 0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (stall || busy) n++;
      end
      check("idle_after_b2b", n, 0);
      check("scoreboard_empty", sb.size(), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1);
   end

endmodule
